dbus_target_router: RTL and testbench

//  Routes one CPU data-bus request (load/store from the MEM stage) to one of four

---
 rtl/dbus_pkg.sv | 15 +
 rtl/dbus_addr_decode.sv | 20 ++
 rtl/dbus_target_router.sv | 78 +++++++
 tb/tb_dbus_target_router.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// dbus_pkg: shared state encoding, target indices and region nibbles for the data-bus router
package dbus_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_ERR} state_t;
  localparam logic [1:0] TGT_DMEM  = 2'd0;
  localparam logic [1:0] TGT_UART  = 2'd1;
  localparam logic [1:0] TGT_TIMER = 2'd2;
  localparam logic [1:0] TGT_GPIO  = 2'd3;
  localparam logic [3:0] REG_DMEM  = 4'h0;
  localparam logic [3:0] REG_UART  = 4'h1;
  localparam logic [3:0] REG_TIMER = 4'h2;
  localparam logic [3:0] REG_GPIO  = 4'h3;
  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction
endpackage

// File: rtl/dbus_addr_decode.sv
// dbus_addr_decode: maps the address region field to a target index plus a mapped flag
module dbus_addr_decode
  import dbus_pkg::*;
#(
  parameter int SEL_HI = 31,
  parameter int SEL_LO = 28
) (
  input  logic [31:0] addr,
  output logic        mapped,
  output logic [1:0]  idx
);
  localparam int W = SEL_HI - SEL_LO + 1;
  logic [W-1:0] region;
  assign region = addr[SEL_HI:SEL_LO];
  assign mapped = region == W'(REG_DMEM) || region == W'(REG_UART) ||
                  region == W'(REG_TIMER) || region == W'(REG_GPIO);
  assign idx = region == W'(REG_UART)  ? TGT_UART  :
               region == W'(REG_TIMER) ? TGT_TIMER :
               region == W'(REG_GPIO)  ? TGT_GPIO  : TGT_DMEM;
endmodule

// File: rtl/dbus_target_router.sv
// dbus_target_router: routes one CPU data-bus access to a target and returns its response
module dbus_target_router
  import dbus_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int SEL_HI  = 31,
  parameter int SEL_LO  = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req_valid,
  output logic         cpu_req_ready,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_wdata,
  input  logic [3:0]   cpu_be,
  output logic         cpu_rsp_valid,
  output logic         cpu_rsp_err,
  output logic [31:0]  cpu_rdata,
  output logic [3:0]   tgt_sel,
  output logic [31:0]  tgt_addr,
  output logic         tgt_we,
  output logic [31:0]  tgt_wdata,
  output logic [3:0]   tgt_be,
  input  logic [3:0]   tgt_ack,
  input  logic [127:0] tgt_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [1:0] idx, dec_idx;
  logic dec_mapped, accept, ack_hit, expire;
  logic [CW-1:0] cnt;
  dbus_addr_decode #(.SEL_HI(SEL_HI), .SEL_LO(SEL_LO)) u_dec (
    .addr(cpu_addr),
    .mapped(dec_mapped),
    .idx(dec_idx)
  );
  assign cpu_req_ready = !rst && state == S_IDLE;
  assign accept = state == S_IDLE && cpu_req_valid;
  assign ack_hit = state == S_ACCESS && tgt_ack[idx];
  assign expire = cnt == CW'(TIMEOUT - 1);
  // next state: an ack in the final timeout cycle still wins over the error
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE   ? (cpu_req_valid ? (dec_mapped ? S_ACCESS : S_ERR) : S_IDLE) :
              state == S_ACCESS ? (ack_hit ? S_RESP : (expire ? S_ERR : S_ACCESS)) : S_IDLE;
  end
  // state, timeout counter, latched request and registered outputs derived from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      tgt_sel       <= '0;
      tgt_addr      <= '0;
      tgt_we        <= 1'b0;
      tgt_wdata     <= '0;
      tgt_be        <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_err   <= 1'b0;
      cpu_rdata     <= '0;
    end else begin
      state         <= state_n;
      cnt           <= (state == S_ACCESS && !ack_hit) ? cnt + 1'b1 : '0;
      tgt_sel       <= state_n == S_ACCESS ? onehot(accept ? dec_idx : idx) : '0;
      cpu_rsp_valid <= state_n == S_RESP || state_n == S_ERR;
      cpu_rsp_err   <= state_n == S_ERR;
      cpu_rdata     <= (ack_hit && !tgt_we) ? tgt_rdata[32*idx +: 32] : '0;
      if (accept) begin
        idx       <= dec_idx;
        tgt_addr  <= cpu_addr;
        tgt_we    <= cpu_we;
        tgt_wdata <= cpu_wdata;
        tgt_be    <= cpu_be;
      end
    end
  end
endmodule

// File: tb/tb_dbus_target_router.sv
// tb_dbus_target_router: directed checks of routing, latency, errors, timeout and reset abort
module tb_dbus_target_router;
  logic clk = 0, rst = 1;
  logic cpu_req_valid = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic [3:0] cpu_be = 0, tgt_ack = 0;
  logic [127:0] tgt_rdata = 0;
  logic cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, tgt_we;
  logic [31:0] cpu_rdata, tgt_addr, tgt_wdata;
  logic [3:0] tgt_sel, tgt_be;
  int n_cmp = 0, n_err = 0, sel_cnt;
  dbus_target_router dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_err(cpu_rsp_err), .cpu_rdata(cpu_rdata),
    .tgt_sel(tgt_sel), .tgt_addr(tgt_addr), .tgt_we(tgt_we), .tgt_wdata(tgt_wdata),
    .tgt_be(tgt_be), .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_sel", 32'(tgt_sel), 0);
    chk("rst_rsp", 32'(cpu_rsp_valid), 0);
    chk("rst_err", 32'(cpu_rsp_err), 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_taddr", tgt_addr, 0);
    chk("rst_ready", 32'(cpu_req_ready), 0);
    rst = 0;
    #1;
    chk("idle_ready", 32'(cpu_req_ready), 1);
    // 1: load DMEM, immediate ack
    cpu_req_valid = 1; cpu_addr = 32'h0000_0010; cpu_we = 0; cpu_be = 4'hf;
    tgt_rdata[31:0] = 32'hDEAD_BEEF; tgt_ack = 4'b0001;
    tick();
    cpu_req_valid = 0;
    chk("t1_sel", 32'(tgt_sel), 32'b0001);
    chk("t1_ready", 32'(cpu_req_ready), 0);
    chk("t1_taddr", tgt_addr, 32'h0000_0010);
    chk("t1_norsp", 32'(cpu_rsp_valid), 0);
    tick();
    tgt_ack = 0;
    chk("t1_rsp", 32'(cpu_rsp_valid), 1);
    chk("t1_err", 32'(cpu_rsp_err), 0);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_seloff", 32'(tgt_sel), 0);
    tick();
    chk("t1_rspend", 32'(cpu_rsp_valid), 0);
    chk("t1_ready2", 32'(cpu_req_ready), 1);
    // 2: store TIMER, ack after 3 waiting cycles
    cpu_req_valid = 1; cpu_addr = 32'h2000_0004; cpu_we = 1; cpu_wdata = 32'h1234_5678; cpu_be = 4'b0011;
    tgt_rdata[95:64] = 32'hAAAA_5555;
    tick();
    cpu_req_valid = 0; cpu_wdata = 0; cpu_be = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_sel", 32'(tgt_sel), 32'b0100);
      chk("t2_wdata", tgt_wdata, 32'h1234_5678);
      chk("t2_be", 32'(tgt_be), 32'b0011);
      tick();
    end
    chk("t2_sel4", 32'(tgt_sel), 32'b0100);
    chk("t2_we", 32'(tgt_we), 1);
    tgt_ack = 4'b0100;
    tick();
    tgt_ack = 0;
    chk("t2_rsp", 32'(cpu_rsp_valid), 1);
    chk("t2_err", 32'(cpu_rsp_err), 0);
    chk("t2_rdata", cpu_rdata, 0);
    chk("t2_seloff", 32'(tgt_sel), 0);
    tick();
    // 3: unmapped load
    cpu_req_valid = 1; cpu_addr = 32'h8000_0000; cpu_we = 0;
    tick();
    cpu_req_valid = 0;
    chk("t3_sel", 32'(tgt_sel), 0);
    chk("t3_rsp", 32'(cpu_rsp_valid), 1);
    chk("t3_err", 32'(cpu_rsp_err), 1);
    chk("t3_rdata", cpu_rdata, 0);
    tick();
    chk("t3_rspend", 32'(cpu_rsp_valid), 0);
    // 4a: GPIO load with no ack times out
    cpu_req_valid = 1; cpu_addr = 32'h3000_0000;
    tgt_rdata[127:96] = 32'hCAFE_F00D;
    tick();
    cpu_req_valid = 0;
    sel_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (tgt_sel == 4'b1000) sel_cnt++;
      chk("t4_norsp", 32'(cpu_rsp_valid), 0);
      tick();
    end
    chk("t4_selcycles", 32'(sel_cnt), 16);
    chk("t4_rsp", 32'(cpu_rsp_valid), 1);
    chk("t4_err", 32'(cpu_rsp_err), 1);
    chk("t4_rdata", cpu_rdata, 0);
    chk("t4_seloff", 32'(tgt_sel), 0);
    tick();
    // 4b: ack on the 16th ACCESS cycle wins over timeout
    cpu_req_valid = 1;
    tick();
    cpu_req_valid = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("t4b_sel16", 32'(tgt_sel), 32'b1000);
    tgt_ack = 4'b1000;
    tick();
    tgt_ack = 0;
    chk("t4b_rsp", 32'(cpu_rsp_valid), 1);
    chk("t4b_err", 32'(cpu_rsp_err), 0);
    chk("t4b_rdata", cpu_rdata, 32'hCAFE_F00D);
    tick();
    // 5: spurious acks ignored, reset aborts mid-ACCESS
    cpu_req_valid = 1; cpu_addr = 32'h1000_0008;
    tgt_rdata[63:32] = 32'h5151_5151;
    tick();
    cpu_req_valid = 0;
    chk("t5_sel", 32'(tgt_sel), 32'b0010);
    tgt_ack = 4'b1001;
    tick();
    chk("t5_spur_sel", 32'(tgt_sel), 32'b0010);
    chk("t5_spur_rsp", 32'(cpu_rsp_valid), 0);
    rst = 1;
    tick();
    chk("t5_rst_sel", 32'(tgt_sel), 0);
    chk("t5_rst_rsp", 32'(cpu_rsp_valid), 0);
    rst = 0; tgt_ack = 0;
    #1;
    chk("t5_ready", 32'(cpu_req_ready), 1);
    tick();
    chk("t5_rsp2", 32'(cpu_rsp_valid), 0);
    chk("t5_sel2", 32'(tgt_sel), 0);
    // 6: back-to-back loads with valid held
    cpu_req_valid = 1; cpu_addr = 32'h0000_0000;
    tgt_rdata[31:0] = 32'h1111_1111; tgt_rdata[127:96] = 32'h3333_3333; tgt_ack = 4'b0001;
    tick();
    chk("t6_sel0", 32'(tgt_sel), 32'b0001);
    tick();
    cpu_addr = 32'h3000_0040;
    chk("t6_rsp0", cpu_rdata, 32'h1111_1111);
    chk("t6_rsp_ready", 32'(cpu_req_ready), 0);
    tick();
    tgt_ack = 4'b1000;
    chk("t6_idle_ready", 32'(cpu_req_ready), 1);
    chk("t6_idle_sel", 32'(tgt_sel), 0);
    tick();
    cpu_req_valid = 0;
    chk("t6_sel3", 32'(tgt_sel), 32'b1000);
    chk("t6_taddr", tgt_addr, 32'h3000_0040);
    tick();
    tgt_ack = 0;
    chk("t6_rsp3", 32'(cpu_rsp_valid), 1);
    chk("t6_rdata3", cpu_rdata, 32'h3333_3333);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
